computer_interface_mc: RTL and testbench

Multi-channel, width-parametrised host link. On each rising edge of the ADC sample strobe it serialises a snapshot of all ADC channels into a framed 7-bit-payload byte stream on the byte-level TX handshake of `fifo_interface` (FTDI FT2232H FIFO). It then polls the RX side for a matching frame and updates all DAC channels atomically. Compared with the two-byte, single-channel version, it adds generic sample width and channel count, strict frame checking, atomic DAC update, and overrun and error indication.

---
 rtl/computer_interface_mc.sv | 180 ++++++++++++++++++
 tb/tb_computer_interface_mc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/computer_interface_mc.sv
// Frames an ADC snapshot into a 7-bit-payload byte stream. The first byte goes out 1 cycle after the strobe edge, and each later byte or RX poll 1 cycle after its handshake.
// Backpressure: one request is outstanding at a time and is held until tx_ok/tx_err or rx_rdy/rx_err arrives; a strobe edge that is not seen in IDLE is dropped and flagged as an overrun.
module computer_interface_mc #(
  parameter int DATA_W     = 14,
  parameter int CHANNELS   = 2,
  parameter int LEDCNT_MAX = 7200000
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [CHANNELS*DATA_W-1:0]   adc_data_i,
  input  logic                         adc_data_rdy_i,
  output logic [CHANNELS*DATA_W-1:0]   dac_data_o,
  output logic                         dac_data_rdy_o,
  output logic [7:0]                   tx_data_o,
  output logic                         tx_data_rdy_o,
  input  logic                         tx_ok_i,
  input  logic                         tx_err_i,
  output logic                         rx_poll_o,
  input  logic                         rx_data_rdy_i,
  input  logic                         rx_err_i,
  input  logic [7:0]                   rx_data_i,
  output logic                         led_txerr_o,
  output logic                         led_rxerr_o,
  output logic                         led_ovr_o
);

  localparam int NB    = (DATA_W + 6) / 7;
  localparam int FB    = NB * CHANNELS;
  localparam int FW    = FB * 7;
  localparam int IDX_W = $clog2(FB) + 1;
  localparam int LED_W = $clog2(LEDCNT_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FB - 1);
  localparam logic [LED_W-1:0] LED_LOAD = LED_W'(LEDCNT_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TX   = 2'd1;
  localparam logic [1:0] S_RX   = 2'd2;

  logic [1:0]                 state;
  logic [IDX_W-1:0]           idx;
  logic                       strobe_q;
  logic                       strobe_armed;
  logic [FW-1:0]              adc_frame;
  logic [FW-1:0]              tx_shift;
  logic [FW-1:0]              rx_shift;
  logic [FW-1:0]              rx_next;
  logic [CHANNELS*DATA_W-1:0] rx_dac;
  logic [LED_W-1:0]           txerr_cnt;
  logic [LED_W-1:0]           rxerr_cnt;
  logic [LED_W-1:0]           ovr_cnt;
  logic                       edge_vld;
  logic                       idx_last;
  logic                       sync_ok;
  logic                       ovr_load;
  logic                       txerr_load;
  logic                       rxerr_load;

  // Frames are held in wire order: byte 0 sits in the top 7 bits, each channel zero-padded to NB*7 bits.
  always_comb begin
    adc_frame = '0;
    rx_dac    = '0;
    rx_next   = (rx_shift << 7) | FW'(rx_data_i[6:0]);
    for (int k = 0; k < CHANNELS; k++) begin
      adc_frame[(CHANNELS-1-k)*NB*7 +: DATA_W] = adc_data_i[k*DATA_W +: DATA_W];
      rx_dac[k*DATA_W +: DATA_W] = rx_next[(CHANNELS-1-k)*NB*7 +: DATA_W];
    end
  end

  // The strobe is armed one cycle after reset, so an input held high through reset is not seen as an edge.
  assign edge_vld   = adc_data_rdy_i & ~strobe_q & strobe_armed;
  assign idx_last   = (idx == LAST_IDX);
  assign sync_ok    = (rx_data_i[7] == (idx == '0));
  assign ovr_load   = edge_vld && (state != S_IDLE);
  assign txerr_load = (state == S_TX) && !tx_ok_i && tx_err_i;
  assign rxerr_load = (state == S_RX) &&
                      ((rx_data_rdy_i && !sync_ok) || (!rx_data_rdy_i && rx_err_i && (idx != '0)));

  assign led_txerr_o = |txerr_cnt;
  assign led_rxerr_o = |rxerr_cnt;
  assign led_ovr_o   = |ovr_cnt;

  function automatic logic [LED_W-1:0] cnt_next(input logic load, input logic [LED_W-1:0] cnt);
    if (load)            return LED_LOAD;
    else if (cnt != '0)  return cnt - 1'b1;
    else                 return '0;
  endfunction

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state          <= S_IDLE;
      idx            <= '0;
      strobe_q       <= 1'b0;
      strobe_armed   <= 1'b0;
      tx_shift       <= '0;
      rx_shift       <= '0;
      tx_data_o      <= '0;
      tx_data_rdy_o  <= 1'b0;
      rx_poll_o      <= 1'b0;
      dac_data_o     <= '0;
      dac_data_rdy_o <= 1'b0;
      txerr_cnt      <= '0;
      rxerr_cnt      <= '0;
      ovr_cnt        <= '0;
    end else begin
      strobe_q       <= adc_data_rdy_i;
      strobe_armed   <= 1'b1;
      tx_data_rdy_o  <= 1'b0;
      rx_poll_o      <= 1'b0;
      dac_data_rdy_o <= 1'b0;
      txerr_cnt      <= cnt_next(txerr_load, txerr_cnt);
      rxerr_cnt      <= cnt_next(rxerr_load, rxerr_cnt);
      ovr_cnt        <= cnt_next(ovr_load, ovr_cnt);
      case (state)
        S_IDLE: begin
          if (edge_vld) begin
            tx_data_o     <= {1'b1, adc_frame[FW-1 -: 7]};
            tx_shift      <= adc_frame << 7;
            tx_data_rdy_o <= 1'b1;
            idx           <= '0;
            state         <= S_TX;
          end
        end
        S_TX: begin
          if (tx_ok_i) begin
            if (idx_last) begin
              rx_poll_o <= 1'b1;
              idx       <= '0;
              rx_shift  <= '0;
              state     <= S_RX;
            end else begin
              tx_data_o     <= {1'b0, tx_shift[FW-1 -: 7]};
              tx_shift      <= tx_shift << 7;
              tx_data_rdy_o <= 1'b1;
              idx           <= idx + 1'b1;
            end
          end else if (tx_err_i) begin
            rx_poll_o <= 1'b1;
            idx       <= '0;
            rx_shift  <= '0;
            state     <= S_RX;
          end
        end
        S_RX: begin
          if (rx_data_rdy_i) begin
            if (!sync_ok) begin
              state <= S_IDLE;
            end else if (idx_last) begin
              dac_data_o     <= rx_dac;
              dac_data_rdy_o <= 1'b1;
              state          <= S_IDLE;
            end else begin
              rx_shift  <= rx_next;
              idx       <= idx + 1'b1;
              rx_poll_o <= 1'b1;
            end
          end else if (rx_err_i) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state          <= S_IDLE;
          idx            <= '0;
          strobe_q       <= 1'b0;
          strobe_armed   <= 1'b0;
          tx_shift       <= '0;
          rx_shift       <= '0;
          tx_data_o      <= '0;
          tx_data_rdy_o  <= 1'b0;
          rx_poll_o      <= 1'b0;
          dac_data_o     <= '0;
          dac_data_rdy_o <= 1'b0;
          txerr_cnt      <= '0;
          rxerr_cnt      <= '0;
          ovr_cnt        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_computer_interface_mc.sv
// Directed checks of the host-link framing, handshakes, error LEDs and async reset on two configurations.
module tb_computer_interface_mc;

  localparam int DW_A = 14;
  localparam int CH_A = 2;
  localparam int DW_B = 8;
  localparam int CH_B = 1;
  localparam int LM   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Configuration A: 14-bit samples, 2 channels
  logic                   rst_na = 1'b0;
  logic [CH_A*DW_A-1:0]   adc_a = '0;
  logic                   strobe_a = 1'b0;
  logic [CH_A*DW_A-1:0]   dac_a;
  logic                   dac_rdy_a;
  logic [7:0]             tx_a;
  logic                   tx_rdy_a;
  logic                   tx_ok_a = 1'b0;
  logic                   tx_err_a = 1'b0;
  logic                   poll_a;
  logic                   rx_rdy_a = 1'b0;
  logic                   rx_err_a = 1'b0;
  logic [7:0]             rx_dat_a = '0;
  logic                   led_tx_a, led_rx_a, led_ovr_a;

  // Configuration B: 8-bit samples, 1 channel
  logic                   rst_nb = 1'b0;
  logic [CH_B*DW_B-1:0]   adc_b = '0;
  logic                   strobe_b = 1'b0;
  logic [CH_B*DW_B-1:0]   dac_b;
  logic                   dac_rdy_b;
  logic [7:0]             tx_b;
  logic                   tx_rdy_b;
  logic                   tx_ok_b = 1'b0;
  logic                   poll_b;
  logic                   led_tx_b, led_rx_b, led_ovr_b;
  logic                   zero_b = 1'b0;
  logic [7:0]             zero8_b = '0;

  computer_interface_mc #(.DATA_W(DW_A), .CHANNELS(CH_A), .LEDCNT_MAX(LM)) dut_a (
    .clk_i(clk), .reset_ni(rst_na),
    .adc_data_i(adc_a), .adc_data_rdy_i(strobe_a),
    .dac_data_o(dac_a), .dac_data_rdy_o(dac_rdy_a),
    .tx_data_o(tx_a), .tx_data_rdy_o(tx_rdy_a),
    .tx_ok_i(tx_ok_a), .tx_err_i(tx_err_a),
    .rx_poll_o(poll_a), .rx_data_rdy_i(rx_rdy_a), .rx_err_i(rx_err_a), .rx_data_i(rx_dat_a),
    .led_txerr_o(led_tx_a), .led_rxerr_o(led_rx_a), .led_ovr_o(led_ovr_a)
  );

  computer_interface_mc #(.DATA_W(DW_B), .CHANNELS(CH_B), .LEDCNT_MAX(LM)) dut_b (
    .clk_i(clk), .reset_ni(rst_nb),
    .adc_data_i(adc_b), .adc_data_rdy_i(strobe_b),
    .dac_data_o(dac_b), .dac_data_rdy_o(dac_rdy_b),
    .tx_data_o(tx_b), .tx_data_rdy_o(tx_rdy_b),
    .tx_ok_i(tx_ok_b), .tx_err_i(zero_b),
    .rx_poll_o(poll_b), .rx_data_rdy_i(zero_b), .rx_err_i(zero_b), .rx_data_i(zero8_b),
    .led_txerr_o(led_tx_b), .led_rxerr_o(led_rx_b), .led_ovr_o(led_ovr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One idle cycle after the request, then a single-cycle completion status.
  task automatic a_tx(input logic ok, input logic err);
    tick();
    chk("a_tx_pulse_width", 64'(tx_rdy_a), 64'd0);
    tx_ok_a  = ok;
    tx_err_a = err;
    tick();
    tx_ok_a  = 1'b0;
    tx_err_a = 1'b0;
  endtask

  task automatic a_rx(input logic rdy, input logic err, input logic [7:0] b);
    tick();
    rx_dat_a = b;
    rx_rdy_a = rdy;
    rx_err_a = err;
    tick();
    rx_rdy_a = 1'b0;
    rx_err_a = 1'b0;
  endtask

  task automatic a_edge();
    strobe_a = 1'b0;
    tick();
    strobe_a = 1'b1;
    tick();
    strobe_a = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_a_tx", {tx_rdy_a, tx_a}, 64'h0);
    chk("rst_a_poll_dac", {poll_a, dac_rdy_a, dac_a}, 64'h0);
    chk("rst_a_leds", {led_tx_a, led_rx_a, led_ovr_a}, 64'h0);
    chk("rst_b_all", {tx_rdy_b, tx_b, poll_b, dac_rdy_b, dac_b}, 64'h0);
    rst_na = 1'b1;
    rst_nb = 1'b1;
    tick();
    tick();

    // Frame out, host has nothing to send back
    adc_a = {14'h0123, 14'h2ABC};
    a_edge();
    chk("t1_byte0", {tx_rdy_a, tx_a}, {1'b1, 8'hD5});
    a_tx(1'b1, 1'b0);
    chk("t1_byte1", {tx_rdy_a, tx_a}, {1'b1, 8'h3C});
    a_tx(1'b1, 1'b0);
    chk("t1_byte2", {tx_rdy_a, tx_a}, {1'b1, 8'h02});
    a_tx(1'b1, 1'b0);
    chk("t1_byte3", {tx_rdy_a, tx_a}, {1'b1, 8'h23});
    a_tx(1'b1, 1'b0);
    chk("t1_poll", {poll_a, tx_rdy_a}, 64'b10);
    a_rx(1'b0, 1'b1, 8'h00);
    chk("t1_idle", {poll_a, dac_rdy_a, dac_a}, 64'h0);
    chk("t1_leds", {led_tx_a, led_rx_a, led_ovr_a}, 64'h0);

    // Full RX frame updates both DAC channels
    a_edge();
    chk("t2_byte0", {tx_rdy_a, tx_a}, {1'b1, 8'hD5});
    repeat (4) a_tx(1'b1, 1'b0);
    chk("t2_poll", 64'(poll_a), 64'd1);
    a_rx(1'b1, 1'b0, 8'h81);
    chk("t2_poll_b1", 64'(poll_a), 64'd1);
    a_rx(1'b1, 1'b0, 8'h00);
    a_rx(1'b1, 1'b0, 8'h3F);
    chk("t2_no_early_dac", {dac_rdy_a, dac_a}, 64'h0);
    a_rx(1'b1, 1'b0, 8'h7F);
    chk("t2_dac", {dac_rdy_a, poll_a, dac_a}, {2'b10, 14'h1FFF, 14'h0080});
    tick();
    chk("t2_dac_pulse", {dac_rdy_a, led_rx_a}, 64'h0);

    // Sync flag on byte 1 aborts; DAC held, RX LED for LM cycles
    a_edge();
    repeat (4) a_tx(1'b1, 1'b0);
    a_rx(1'b1, 1'b0, 8'h81);
    a_rx(1'b1, 1'b0, 8'h80);
    chk("t3_rxerr_led", {led_rx_a, dac_rdy_a, poll_a}, 64'b100);
    chk("t3_dac_held", dac_a, {14'h1FFF, 14'h0080});
    repeat (LM - 1) tick();
    chk("t3_led_last", 64'(led_rx_a), 64'd1);
    tick();
    chk("t3_led_off", 64'(led_rx_a), 64'd0);

    // TX error on byte 1 skips bytes 2 and 3
    a_edge();
    chk("t4_byte0", tx_a, 64'hD5);
    a_tx(1'b1, 1'b0);
    chk("t4_byte1", tx_a, 64'h3C);
    a_tx(1'b0, 1'b1);
    chk("t4_poll", {poll_a, tx_rdy_a, led_tx_a}, 64'b101);
    chk("t4_tx_hold", tx_a, 64'h3C);
    a_rx(1'b0, 1'b1, 8'h00);
    chk("t4_silent", {poll_a, led_rx_a, tx_rdy_a}, 64'h0);

    // Overrun: second edge mid-frame is dropped, frame unchanged
    a_edge();
    chk("t5_byte0", tx_a, 64'hD5);
    adc_a = 28'h0;
    tick();
    strobe_a = 1'b1;
    tick();
    strobe_a = 1'b0;
    chk("t5_ovr", {led_ovr_a, tx_rdy_a}, 64'b10);
    a_tx(1'b1, 1'b0);
    chk("t5_byte1", tx_a, 64'h3C);
    a_tx(1'b1, 1'b0);
    chk("t5_byte2", tx_a, 64'h02);
    a_tx(1'b1, 1'b0);
    chk("t5_byte3", tx_a, 64'h23);
    a_tx(1'b1, 1'b0);
    chk("t5_poll", 64'(poll_a), 64'd1);
    a_rx(1'b0, 1'b1, 8'h00);

    // Truncated RX frame raises the RX LED
    a_edge();
    repeat (4) a_tx(1'b1, 1'b0);
    a_rx(1'b1, 1'b0, 8'h81);
    a_rx(1'b0, 1'b1, 8'h00);
    chk("t6_trunc", {led_rx_a, dac_rdy_a}, 64'b10);
    chk("t6_dac_held", dac_a, {14'h1FFF, 14'h0080});

    // Configuration B: 8-bit sample, async reset mid-frame
    adc_b = 8'hA5;
    tick();
    strobe_b = 1'b1;
    tick();
    chk("b_byte0", {tx_rdy_b, tx_b}, {1'b1, 8'h81});
    tick();
    tx_ok_b = 1'b1;
    tick();
    tx_ok_b = 1'b0;
    chk("b_byte1", {tx_rdy_b, tx_b}, {1'b1, 8'h25});
    #2;
    rst_nb = 1'b0;
    #1;
    chk("b_async_rst", {tx_rdy_b, tx_b, poll_b, dac_rdy_b, dac_b}, 64'h0);
    chk("b_async_leds", {led_tx_b, led_rx_b, led_ovr_b}, 64'h0);
    tick();
    tick();
    rst_nb = 1'b1;
    tick();
    tick();
    tick();
    chk("b_no_edge_held_high", {tx_rdy_b, tx_b}, 64'h0);
    strobe_b = 1'b0;
    tick();
    strobe_b = 1'b1;
    tick();
    chk("b_edge_after_rst", {tx_rdy_b, tx_b}, {1'b1, 8'h81});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
